fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end that drives the PC into the instruction memory and captures the combinationally read word.
- Buffers fetched {pc, inst} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects from execute.
- Snoops instruction-memory stores so that code written by the loader is never issued stale.

Parameters:
- RESET_PC, 27'h3FB4, byte address fetched after reset (word 4077, the loader entry).
- DEPTH, 2, FIFO entries (integer, >= 2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- imem_pc  output  27  byte PC to instruction memory; memory word index is imem_pc[13:2].
- imem_inst  input  32  instruction read combinationally for imem_pc in the same cycle.
- redirect_valid  input  1  execute requests a PC change.
- redirect_pc  input  27  redirect target; bits [1:0] are ignored and forced to 0.
- st_valid  input  1  a store to the instruction-memory region commits at the next posedge.
- st_waddr  input  12  word index of that store.
- id_valid  output  1  head FIFO entry is valid.
- id_ready  input  1  decode accepts the head entry this cycle.
- id_inst  output  32  head instruction.
- id_pc  output  27  head PC.

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc <= RESET_PC; FIFO count <= 0; all entries cleared.
  - id_valid=0, id_inst=0, id_pc=0; imem_pc=RESET_PC.
  - Reset mid-operation discards all buffered entries and any pending redirect.
- imem_pc = fetch_pc, combinational. fetch_pc[1:0] is always 0.
- Pop: id_valid & id_ready at a posedge removes the head. id_inst and id_pc stay stable while id_valid=1 and id_ready=0. When empty, id_inst=0 and id_pc=0.
- Enqueue condition: count < DEPTH, or (count == DEPTH and a pop occurs this cycle). Simultaneous pop and enqueue on a full FIFO keeps count = DEPTH.
- Normal fetch, when the enqueue condition holds and no event below applies:
  - push {fetch_pc, imem_inst};
  - fetch_pc <= fetch_pc + 4, modulo 2^27 (27'h7FFFFFC wraps to 0).
- Full FIFO with no pop: fetch_pc holds and nothing is pushed.
- Latency: a word fetched at cycle n appears on id_* at cycle n+1 if the FIFO was empty.
- Event priority: redirect > store snoop > normal fetch.
- Redirect (redirect_valid=1):
  - FIFO flushed (count <= 0), including any entry popped that same cycle. The pop is still counted as taken by decode.
  - fetch_pc <= {redirect_pc[26:2], 2'b00}; no push that cycle.
  - Target is on imem_pc at n+1 and on id_* at n+2.
  - Back-to-back redirects: the last one wins.
- Store snoop (st_valid=1, no redirect):
  - Entry hit: st_waddr equals pc[13:2] of any valid entry not being popped this cycle. The FIFO is flushed and fetch_pc <= pc of the oldest remaining entry, so the sequence is refetched. No push that cycle.
  - In-flight hit: otherwise, if st_waddr == fetch_pc[13:2], the in-flight read is stale. No push and fetch_pc holds; the word is refetched next cycle and sees the new data.
  - Miss: normal fetch.
- Matching uses word index [13:2] only; aliasing above bit 13 counts as a hit (conservative refetch).
- Order preservation: entries leave in fetch order. Duplicates and skipped PCs are forbidden except across a redirect.

Test Plan:
- Reset, id_ready=1, memory word i = 32'hA000_0000+i -> imem_pc=27'h3FB4; id_pc/id_inst = 3FB4/A0000FED, then 3FB8/A0000FEE on consecutive cycles.
- id_ready=0 for 5 cycles after reset -> id_valid=1 and id_pc=3FB4 held; imem_pc stalls at 3FBC (2 entries full); release -> 3FB4, 3FB8, 3FBC in order.
- Redirect to 27'h0103 while 2 entries are buffered -> next cycle imem_pc=0x100, id_valid=0; following cycle id_pc=0x100.
- Store st_waddr=12'hFEE (buffered entry 3FB8, head 3FB4 stalled) with new data 32'h1234_5678 -> flush; id shows 3FB4 then 3FB8/12345678.
- Store to fetch_pc's word while the FIFO is empty -> no push that cycle; the next cycle pushes the new value; no old value is ever presented.
- Redirect to 27'h7FFFFFC with id_ready=1 -> id_pc sequence 7FFFFFC, 0000000, 0000004 (wrap).
- Simultaneous redirect and st_valid hit -> redirect target fetched; snoop ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: drives the PC to instruction memory, buffers {pc, inst}
// pairs in a shift FIFO, and handles redirects and instruction-memory store snooping.
module fetch_stage #(
  parameter logic [26:0] RESET_PC = 27'h3FB4,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [26:0] imem_pc,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [26:0] redirect_pc,
  input  logic        st_valid,
  input  logic [11:0] st_waddr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [26:0] id_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [26:0]   fetch_pc, fetch_pc_nxt;
  logic [CW-1:0] count, count_nxt, count_kept;
  logic [26:0]   ent_pc       [DEPTH];
  logic [31:0]   ent_inst     [DEPTH];
  logic [26:0]   ent_pc_nxt   [DEPTH];
  logic [31:0]   ent_inst_nxt [DEPTH];
  logic          pop, can_enq, entry_hit, flight_hit;
  logic [26:0]   oldest_pc;

  // Slot 0 is the head; unused slots are kept at zero so empty shows id_pc/id_inst = 0.
  assign imem_pc  = fetch_pc;
  assign id_valid = (count != '0);
  assign id_pc    = ent_pc[0];
  assign id_inst  = ent_inst[0];

  always_comb begin
    pop        = (count != '0) && id_ready;
    can_enq    = (count < CW'(DEPTH)) || pop;
    flight_hit = (st_waddr == fetch_pc[13:2]);
    entry_hit  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && !((i == 0) && pop) && (ent_pc[AW'(i)][13:2] == st_waddr))
        entry_hit = 1'b1;
    end
    oldest_pc    = pop ? ent_pc[1] : ent_pc[0];
    count_kept   = count - CW'(pop);
    fetch_pc_nxt = fetch_pc;
    count_nxt    = count_kept;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!pop) begin
        ent_pc_nxt[AW'(i)]   = ent_pc[AW'(i)];
        ent_inst_nxt[AW'(i)] = ent_inst[AW'(i)];
      end else if (i == DEPTH - 1) begin
        ent_pc_nxt[AW'(i)]   = '0;
        ent_inst_nxt[AW'(i)] = '0;
      end else begin
        ent_pc_nxt[AW'(i)]   = ent_pc[AW'((i + 1) % DEPTH)];
        ent_inst_nxt[AW'(i)] = ent_inst[AW'((i + 1) % DEPTH)];
      end
    end

    if (redirect_valid || (st_valid && entry_hit)) begin
      // Flush; a snoop hit refetches from the oldest entry that survives this cycle's pop.
      count_nxt    = '0;
      fetch_pc_nxt = redirect_valid ? (redirect_pc & ~27'h3) : oldest_pc;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_pc_nxt[AW'(i)]   = '0;
        ent_inst_nxt[AW'(i)] = '0;
      end
    end else if (st_valid && flight_hit) begin
      fetch_pc_nxt = fetch_pc;
    end else if (can_enq) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_kept) begin
          ent_pc_nxt[AW'(i)]   = fetch_pc;
          ent_inst_nxt[AW'(i)] = imem_inst;
        end
      end
      count_nxt    = count_kept + CW'(1);
      fetch_pc_nxt = fetch_pc + 27'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_pc[AW'(i)]   <= '0;
        ent_inst[AW'(i)] <= '0;
      end
    end else begin
      fetch_pc <= fetch_pc_nxt;
      count    <= count_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_pc[AW'(i)]   <= ent_pc_nxt[AW'(i)];
        ent_inst[AW'(i)] <= ent_inst_nxt[AW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural instruction memory plus a
// scoreboard of expected {pc, inst} pairs accepted by decode.
module tb_fetch_stage;

  typedef struct packed {
    logic [26:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [26:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [26:0] redirect_pc = '0;
  logic        st_valid = 1'b0;
  logic [11:0] st_waddr = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst;
  logic [26:0] id_pc;

  logic [31:0] mem [4096];
  ent_t        sb [$];
  ent_t        exp_e;
  int          checks = 0;
  int          errors = 0;
  int          budget;

  assign imem_inst = mem[imem_pc[13:2]];

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .st_valid(st_valid), .st_waddr(st_waddr),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(input logic [26:0] pc);
    mk.pc   = pc;
    mk.inst = 32'hA000_0000 + 32'(pc[13:2]);
  endfunction

  task automatic apply_reset(input logic ready);
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + 32'(i);
    sb.delete();
    rst = 1'b1; redirect_valid = 1'b0; st_valid = 1'b0; id_ready = ready;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    checks++;
    if (imem_pc !== 27'h3FB4 || id_valid !== 1'b0 || id_pc !== 27'h0 || id_inst !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: imem_pc=%h id_valid=%b id_pc=%h id_inst=%h, want 3fb4 0 0 0",
               imem_pc, id_valid, id_pc, id_inst);
    end
    sb.push_back(mk(27'h3FB4)); sb.push_back(mk(27'h3FB8)); sb.push_back(mk(27'h3FBC));
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 27'h3FB4 || id_inst !== 32'hA000_0FED) begin
      errors++;
      $display("FAIL first_latency: id_valid=%b id_pc=%h id_inst=%h, want 1 3fb4 a0000fed",
               id_valid, id_pc, id_inst);
    end
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      if (id_valid && id_ready) begin
        exp_e = sb.pop_front(); checks++;
        if (id_pc !== exp_e.pc || id_inst !== exp_e.inst) begin
          errors++;
          $display("FAIL reset_seq: got %h/%h want %h/%h", id_pc, id_inst, exp_e.pc, exp_e.inst);
        end
      end
      tick(); budget++;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL reset_seq_timeout: %0d left, want 0", sb.size()); end
    // Reset while entries are buffered and a redirect is pending
    apply_reset(1'b0);
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 27'h500; rst = 1'b1;
    tick();
    rst = 1'b0; redirect_valid = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || imem_pc !== 27'h3FB4) begin
      errors++;
      $display("FAIL midop_reset: id_valid=%b imem_pc=%h, want 0 3fb4", id_valid, imem_pc);
    end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 27'h3FB4) begin
      errors++;
      $display("FAIL midop_reset_refetch: id_valid=%b id_pc=%h, want 1 3fb4", id_valid, id_pc);
    end
  endtask

  task automatic test_stall();
    apply_reset(1'b0);
    repeat (5) tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 27'h3FB4 || id_inst !== 32'hA000_0FED || imem_pc !== 27'h3FBC) begin
      errors++;
      $display("FAIL stall_hold: id_valid=%b id_pc=%h id_inst=%h imem_pc=%h, want 1 3fb4 a0000fed 3fbc",
               id_valid, id_pc, id_inst, imem_pc);
    end
    for (int k = 0; k < 5; k++) sb.push_back(mk(27'h3FB4 + 27'(4 * k)));
    id_ready = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      if (id_valid && id_ready) begin
        exp_e = sb.pop_front(); checks++;
        if (id_pc !== exp_e.pc || id_inst !== exp_e.inst) begin
          errors++;
          $display("FAIL stall_seq: got %h/%h want %h/%h", id_pc, id_inst, exp_e.pc, exp_e.inst);
        end
      end
      tick(); budget++;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stall_seq_timeout: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_redirect();
    apply_reset(1'b0);
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 27'h0103;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_pc !== 27'h100 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_flush: imem_pc=%h id_valid=%b, want 100 0", imem_pc, id_valid);
    end
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 27'h100 || id_inst !== 32'hA000_0040) begin
      errors++;
      $display("FAIL redirect_target: id_valid=%b id_pc=%h id_inst=%h, want 1 100 a0000040",
               id_valid, id_pc, id_inst);
    end
    for (int k = 0; k < 3; k++) sb.push_back(mk(27'h100 + 27'(4 * k)));
    id_ready = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      if (id_valid && id_ready) begin
        exp_e = sb.pop_front(); checks++;
        if (id_pc !== exp_e.pc || id_inst !== exp_e.inst) begin
          errors++;
          $display("FAIL redirect_seq: got %h/%h want %h/%h", id_pc, id_inst, exp_e.pc, exp_e.inst);
        end
      end
      tick(); budget++;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL redirect_seq_timeout: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_store_entry();
    apply_reset(1'b0);
    tick(); tick();
    st_valid = 1'b1; st_waddr = 12'hFEE;
    tick();
    mem[12'hFEE] = 32'h1234_5678;
    st_valid = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || imem_pc !== 27'h3FB4) begin
      errors++;
      $display("FAIL snoop_entry_flush: id_valid=%b imem_pc=%h, want 0 3fb4", id_valid, imem_pc);
    end
    sb.push_back(mk(27'h3FB4));
    exp_e.pc = 27'h3FB8; exp_e.inst = 32'h1234_5678; sb.push_back(exp_e);
    sb.push_back(mk(27'h3FBC));
    id_ready = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      if (id_valid && id_ready) begin
        exp_e = sb.pop_front(); checks++;
        if (id_pc !== exp_e.pc || id_inst !== exp_e.inst) begin
          errors++;
          $display("FAIL snoop_entry_seq: got %h/%h want %h/%h", id_pc, id_inst, exp_e.pc, exp_e.inst);
        end
      end
      tick(); budget++;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL snoop_entry_timeout: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_store_inflight();
    apply_reset(1'b1);
    st_valid = 1'b1; st_waddr = 12'hFED;
    tick();
    mem[12'hFED] = 32'hDEAD_BEEF;
    st_valid = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || imem_pc !== 27'h3FB4) begin
      errors++;
      $display("FAIL snoop_inflight_hold: id_valid=%b imem_pc=%h, want 0 3fb4", id_valid, imem_pc);
    end
    exp_e.pc = 27'h3FB4; exp_e.inst = 32'hDEAD_BEEF; sb.push_back(exp_e);
    sb.push_back(mk(27'h3FB8));
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      if (id_valid && id_ready) begin
        exp_e = sb.pop_front(); checks++;
        if (id_pc !== exp_e.pc || id_inst !== exp_e.inst) begin
          errors++;
          $display("FAIL snoop_inflight_seq: got %h/%h want %h/%h", id_pc, id_inst, exp_e.pc, exp_e.inst);
        end
      end
      tick(); budget++;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL snoop_inflight_timeout: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_wrap();
    apply_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 27'h7FFFFFC;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_pc !== 27'h7FFFFFC) begin
      errors++;
      $display("FAIL wrap_redirect: imem_pc=%h, want 7fffffc", imem_pc);
    end
    sb.push_back(mk(27'h7FFFFFC)); sb.push_back(mk(27'h0)); sb.push_back(mk(27'h4));
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      if (id_valid && id_ready) begin
        exp_e = sb.pop_front(); checks++;
        if (id_pc !== exp_e.pc || id_inst !== exp_e.inst) begin
          errors++;
          $display("FAIL wrap_seq: got %h/%h want %h/%h", id_pc, id_inst, exp_e.pc, exp_e.inst);
        end
      end
      tick(); budget++;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL wrap_timeout: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_redirect_vs_store();
    apply_reset(1'b0);
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 27'h200;
    st_valid = 1'b1; st_waddr = 12'hFEE;
    tick();
    redirect_valid = 1'b0; st_valid = 1'b0;
    checks++;
    if (imem_pc !== 27'h200 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_priority: imem_pc=%h id_valid=%b, want 200 0", imem_pc, id_valid);
    end
    sb.push_back(mk(27'h200)); sb.push_back(mk(27'h204));
    id_ready = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      if (id_valid && id_ready) begin
        exp_e = sb.pop_front(); checks++;
        if (id_pc !== exp_e.pc || id_inst !== exp_e.inst) begin
          errors++;
          $display("FAIL priority_seq: got %h/%h want %h/%h", id_pc, id_inst, exp_e.pc, exp_e.inst);
        end
      end
      tick(); budget++;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL priority_timeout: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    apply_reset(1'b1);
    tick(); tick();
    // Redirect while an entry is being popped, then a second redirect next cycle
    redirect_valid = 1'b1; redirect_pc = 27'h302;
    tick();
    redirect_pc = 27'h401;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_pc !== 27'h400 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last_wins: imem_pc=%h id_valid=%b, want 400 0", imem_pc, id_valid);
    end
    sb.push_back(mk(27'h400)); sb.push_back(mk(27'h404)); sb.push_back(mk(27'h408));
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      if (id_valid && id_ready) begin
        exp_e = sb.pop_front(); checks++;
        if (id_pc !== exp_e.pc || id_inst !== exp_e.inst) begin
          errors++;
          $display("FAIL b2b_seq: got %h/%h want %h/%h", id_pc, id_inst, exp_e.pc, exp_e.inst);
        end
      end
      tick(); budget++;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_timeout: %0d left, want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_store_entry();
    test_store_inflight();
    test_wrap();
    test_redirect_vs_store();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
